// File: rtl/noc_input_fifo.sv
// Per-port NoC input buffer. A circular flit store feeds a registered head-flit output.
// A write-side framing FSM drops malformed flits, and a packet counter tracks how many complete packets are stored.
module noc_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [2:0]            flit_id,
  output logic                  empty,
  output logic                  full,
  output logic                  pkt_avail,
  output logic                  drop_err
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] ID_HEADER  = 3'b001;
  localparam logic [2:0] ID_PAYLOAD = 3'b010;
  localparam logic [2:0] ID_TAIL    = 3'b100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [DEPTH-1:0]      tail_q, tail_d;
  logic                  drop_err_q, drop_err_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0] din_id;
  logic       framing_ok;
  logic       wr_ok;
  logic       rd_ok;
  logic       wr_tail;
  logic       rd_tail;

  assign din_id  = din[DATA_WIDTH-1 -: 3];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & framing_ok & (~full | rd_ok);
  assign wr_tail = wr_ok & (din_id == ID_TAIL);
  // A side copy of each entry's TAIL bit lets the packet count drop on the read cycle itself.
  // This avoids waiting for the registered RAM output.
  assign rd_tail = rd_ok & tail_q[rd_ptr_q];

  assign dout      = dout_q;
  assign flit_id   = dout_q[DATA_WIDTH-1 -: 3];
  assign pkt_avail = (pkt_cnt_q != '0);
  assign drop_err  = drop_err_q;

  always_comb begin
    framing_ok = 1'b0;
    case (state_q)
      ST_IDLE:   framing_ok = (din_id == ID_HEADER);
      ST_IN_PKT: framing_ok = (din_id == ID_PAYLOAD) || (din_id == ID_TAIL);
      default:   framing_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_err_d = wr_en & ~wr_ok;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (state_q == ST_IDLE) begin
        state_d = ST_IN_PKT;
      end else if (din_id == ID_TAIL) begin
        state_d = ST_IDLE;
      end
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case ({wr_tail, rd_tail})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tail
      assign tail_d[gi] = (wr_ok && (wr_ptr_q == PTR_W'(gi))) ? (din_id == ID_TAIL) : tail_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_cnt_q  <= '0;
      tail_q     <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pkt_cnt_q  <= pkt_cnt_d;
      tail_q     <= tail_d;
      drop_err_q <= drop_err_d;
    end
  end

  // On a full-buffer write with a same-cycle read, both ports hit the same entry.
  // The read returns the old flit.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_noc_input_fifo.sv
// Bench for noc_input_fifo: a vector table, hand sequences, and random traffic.
// Results are compared against a queue-based model of the buffer contents and framing rules.
module tb_noc_input_fifo;

  localparam int DW = 32;
  localparam logic [2:0] H = 3'b001, P = 3'b010, T = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic [2:0]    flit_id;
  logic          empty, full, pkt_avail, drop_err;

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .flit_id(flit_id), .empty(empty), .full(full),
    .pkt_avail(pkt_avail), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: the stored flits in order, the framing state, and the last output values.
  logic [DW-1:0] mq[$];
  bit            m_in_pkt;
  logic [DW-1:0] m_dout;
  bit            m_drop;

  typedef struct {
    bit         wr;
    logic [2:0] id;
    bit         rd;
    bit         e_empty;
    bit         e_full;
    bit         e_pavail;
    bit         e_drop;
    logic [2:0] e_id;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [2:0] id);
    logic [DW-1:0] v;
    v = {id, 29'($urandom)};
    return v;
  endfunction

  function automatic bit model_pavail();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i][DW-1 -: 3] == T) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_in_pkt = 1'b0;
    m_dout = '0;
    m_drop = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".dout"}, dout, m_dout);
    check({tag, ".flit_id"}, {29'd0, flit_id}, {29'd0, m_dout[DW-1 -: 3]});
    check({tag, ".empty"}, {31'd0, empty}, {31'd0, mq.size() == 0});
    check({tag, ".full"}, {31'd0, full}, {31'd0, mq.size() == 8});
    check({tag, ".pkt_avail"}, {31'd0, pkt_avail}, {31'd0, model_pavail()});
    check({tag, ".drop_err"}, {31'd0, drop_err}, {31'd0, m_drop});
  endtask

  // Applies one cycle of stimulus, advances the model, and checks the outputs 1 ns after the edge.
  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input string tag);
    logic [2:0] id;
    bit legal, rok, wok;
    wr_en = wr; din = d; rd_en = rd;
    id    = d[DW-1 -: 3];
    legal = m_in_pkt ? (id == P || id == T) : (id == H);
    rok   = rd && (mq.size() > 0);
    wok   = wr && legal && (mq.size() < 8 || rok);
    if (rok) m_dout = mq.pop_front();
    if (wok) begin
      mq.push_back(d);
      m_in_pkt = (id == H) ? 1'b1 : (id == T) ? 1'b0 : m_in_pkt;
    end
    m_drop = wr && !wok;
    @(posedge clk);
    #1;
    check_model(tag);
    $display("txn %s wr=%0b din=%h rd=%0b -> dout=%h empty=%0b full=%0b pavail=%0b drop=%0b",
             tag, wr, d, rd, dout, empty, full, pkt_avail, drop_err);
  endtask

  task automatic do_reset(input int cycles);
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    check_model("reset");
    rst = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    // Table: the basic packet (HEADER, PAYLOAD, PAYLOAD, TAIL) is written, then read back.
    // The IDLE-state drops and the duplicate-HEADER case follow.
    vecs[0]  = '{1, H, 0, 0, 0, 0, 0, 3'b000};
    vecs[1]  = '{1, P, 0, 0, 0, 0, 0, 3'b000};
    vecs[2]  = '{1, P, 0, 0, 0, 0, 0, 3'b000};
    vecs[3]  = '{1, T, 0, 0, 0, 1, 0, 3'b000};
    vecs[4]  = '{0, H, 1, 0, 0, 1, 0, H};
    vecs[5]  = '{0, H, 1, 0, 0, 1, 0, P};
    vecs[6]  = '{0, H, 1, 0, 0, 1, 0, P};
    vecs[7]  = '{0, H, 1, 1, 0, 0, 0, T};
    vecs[8]  = '{1, P, 0, 1, 0, 0, 1, T};
    vecs[9]  = '{1, T, 0, 1, 0, 0, 1, T};
    vecs[10] = '{1, H, 0, 0, 0, 0, 0, T};
    vecs[11] = '{1, H, 0, 0, 0, 0, 1, T};
    vecs[12] = '{0, H, 1, 1, 0, 0, 0, H};

    model_reset();
    do_reset(2);

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].wr, mk(vecs[i].id), vecs[i].rd, tag);
      check({tag, ".t_empty"}, {31'd0, empty}, {31'd0, vecs[i].e_empty});
      check({tag, ".t_full"}, {31'd0, full}, {31'd0, vecs[i].e_full});
      check({tag, ".t_pavail"}, {31'd0, pkt_avail}, {31'd0, vecs[i].e_pavail});
      check({tag, ".t_drop"}, {31'd0, drop_err}, {31'd0, vecs[i].e_drop});
      check({tag, ".t_id"}, {29'd0, flit_id}, {29'd0, vecs[i].e_id});
    end

    // Full-buffer cases: a write with no read is dropped; a write with a read is accepted.
    do_reset(1);
    step(1, mk(H), 0, "fill_h");
    for (int i = 0; i < 6; i++) step(1, mk(P), 0, "fill_p");
    step(1, mk(T), 0, "fill_t");
    check("full_after_fill", {31'd0, full}, 32'd1);
    step(1, mk(H), 0, "full_drop");
    check("full_drop_pulse", {31'd0, drop_err}, 32'd1);
    step(0, mk(H), 0, "full_idle");
    check("full_drop_oneshot", {31'd0, drop_err}, 32'd0);
    step(1, mk(H), 1, "full_wr_rd");
    check("full_wr_rd_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 8; i++) step(0, '0, 1, "full_drain");
    check("drained_empty", {31'd0, empty}, 32'd1);

    // Back-to-back HEADER/TAIL pairs with concurrent reads exercise pointer wrap.
    do_reset(1);
    step(1, mk(H), 0, "wrap_first");
    for (int i = 1; i < 40; i++) begin
      step(1, mk((i % 2) ? T : H), 1, "wrap");
      check("wrap_count_le1", {31'd0, mq.size() <= 1}, 32'd1);
    end
    step(0, '0, 1, "wrap_last");
    check("wrap_empty", {31'd0, empty}, 32'd1);

    // A reset in the middle of a packet discards the partial packet.
    // The next PAYLOAD must then be dropped.
    do_reset(1);
    step(1, mk(H), 0, "mid_h");
    step(1, mk(P), 0, "mid_p");
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_model("mid_rst");
    rst = 1'b0;
    step(1, mk(P), 0, "post_rst_p");
    check("post_rst_drop", {31'd0, drop_err}, 32'd1);

    // Random traffic, checked only against the model.
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      logic [2:0] id;
      case ($urandom_range(0, 5))
        0, 1:    id = P;
        2:       id = H;
        3:       id = T;
        4:       id = 3'($urandom);
        default: id = m_in_pkt ? T : H;
      endcase
      step($urandom_range(0, 9) < 7, mk(id), $urandom_range(0, 9) < 4, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
